// File: rtl/sdram_device_responder.sv
// sdram_device_responder: SDR SDRAM chip-side model that tracks init, bank state and timing,
// stores write data in a reduced array and returns reads after the programmed CAS latency.
module sdram_device_responder #(
    parameter int AddrWidth    = 13,
    parameter int DataWidth    = 16,
    parameter int RowStoreBits = 2,
    parameter int ColStoreBits = 4,
    parameter int TRcd         = 3,
    parameter int TRp          = 3,
    parameter int TRfc         = 9
) (
    input  logic                 i_dram_clk,
    input  logic                 i_rst,
    input  logic                 i_cs_n,
    input  logic                 i_ras_n,
    input  logic                 i_cas_n,
    input  logic                 i_we_n,
    input  logic [1:0]           i_ba,
    input  logic [AddrWidth-1:0] i_addr,
    input  logic                 i_ldqm,
    input  logic                 i_udqm,
    input  logic [DataWidth-1:0] i_dq,
    output logic [DataWidth-1:0] o_dq,
    output logic [1:0]           o_dq_oe,
    output logic                 o_init_done,
    output logic                 o_err,
    output logic [2:0]           o_err_code
);
    localparam int IdxWidth = 2 + RowStoreBits + ColStoreBits;
    localparam int HalfW    = DataWidth / 2;
    localparam int TW       = 8;

    typedef enum logic [2:0] {INIT_PALL, INIT_REF1, INIT_REF2, INIT_MRS, READY} init_t;
    typedef enum logic [2:0] {C_NOP, C_RD, C_WR, C_ACT, C_PRE, C_REF, C_MRS} cmd_t;

    init_t                   r_state;
    logic [3:0]              r_active;
    logic [RowStoreBits-1:0] r_row  [4];
    logic [TW-1:0]           r_trcd [4];
    logic [TW-1:0]           r_trp  [4];
    logic [TW-1:0]           r_trfc;
    logic [2:0]              r_cl;
    logic [DataWidth-1:0]    r_mem  [2**IdxWidth];
    logic                    r_s1_v, r_s1_cl3, r_s2_v;
    logic [1:0]              r_s1_oe, r_s2_oe;
    logic [DataWidth-1:0]    r_s1_dq, r_s2_dq;

    cmd_t                    w_cmd;
    logic                    w_init_ok, w_en, w_rw, w_acc, w_act, w_pre, w_bank_act, w_mrs_ok;
    logic [2:0]              w_code;
    logic [IdxWidth-1:0]     w_idx;
    logic                    w_unused;

    always_comb begin
        w_cmd = C_NOP;
        if (!i_cs_n) begin
            case ({i_ras_n, i_cas_n, i_we_n})
                3'b101:  w_cmd = C_RD;
                3'b100:  w_cmd = C_WR;
                3'b011:  w_cmd = C_ACT;
                3'b010:  w_cmd = C_PRE;
                3'b001:  w_cmd = C_REF;
                3'b000:  w_cmd = C_MRS;
                default: w_cmd = C_NOP;
            endcase
        end
    end

    assign w_init_ok = (r_state == READY) ||
                       (r_state == INIT_PALL && w_cmd == C_PRE && i_addr[10]) ||
                       ((r_state == INIT_REF1 || r_state == INIT_REF2) && w_cmd == C_REF) ||
                       (r_state == INIT_MRS && w_cmd == C_MRS);
    // Commands during refresh lockout or out of init order are dropped entirely
    assign w_en       = w_cmd != C_NOP && r_trfc == '0 && w_init_ok;
    assign w_rw       = w_cmd == C_RD || w_cmd == C_WR;
    assign w_bank_act = r_active[i_ba];
    assign w_acc      = w_en && w_rw && w_bank_act;
    assign w_act      = w_en && w_cmd == C_ACT;
    assign w_pre      = w_en && w_cmd == C_PRE;
    assign w_mrs_ok   = i_addr[2:0] == 3'd0 && (i_addr[6:4] == 3'd2 || i_addr[6:4] == 3'd3);
    assign w_idx      = {i_ba, r_row[i_ba], i_addr[ColStoreBits-1:0]};
    assign w_unused   = ^i_addr;

    assign w_code = (w_cmd != C_NOP && !w_en)             ? 3'd1 :
                    !w_en                                 ? 3'd0 :
                    (w_cmd == C_ACT && w_bank_act)        ? 3'd3 :
                    (w_cmd == C_ACT && r_trp[i_ba] != '0) ? 3'd5 :
                    (w_rw && !w_bank_act)                 ? 3'd2 :
                    (w_rw && r_trcd[i_ba] != '0)          ? 3'd4 :
                    (w_cmd == C_MRS && !w_mrs_ok)         ? 3'd6 :
                    (w_cmd == C_REF && r_active != '0)    ? 3'd7 : 3'd0;

    always_ff @(posedge i_dram_clk) begin
        if (w_acc && w_cmd == C_WR && !i_ldqm) r_mem[w_idx][HalfW-1:0] <= i_dq[HalfW-1:0];
        if (w_acc && w_cmd == C_WR && !i_udqm) r_mem[w_idx][DataWidth-1:HalfW] <= i_dq[DataWidth-1:HalfW];
    end

    always_ff @(posedge i_dram_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= INIT_PALL;
            r_active    <= '0;
            r_trfc      <= '0;
            r_cl        <= 3'd3;
            r_s1_v      <= 1'b0;
            r_s1_cl3    <= 1'b0;
            r_s1_oe     <= '0;
            r_s1_dq     <= '0;
            r_s2_v      <= 1'b0;
            r_s2_oe     <= '0;
            r_s2_dq     <= '0;
            o_dq        <= '0;
            o_dq_oe     <= '0;
            o_init_done <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= '0;
            for (int b = 0; b < 4; b++) begin
                r_row[b]  <= '0;
                r_trcd[b] <= '0;
                r_trp[b]  <= '0;
            end
        end else begin
            r_state <= (!w_en || r_state == READY) ? r_state :
                       r_state == INIT_PALL ? INIT_REF1 :
                       r_state == INIT_REF1 ? INIT_REF2 :
                       r_state == INIT_REF2 ? INIT_MRS : READY;
            o_init_done <= o_init_done | (w_en && r_state == INIT_MRS);
            r_trfc <= (w_en && w_cmd == C_REF && r_active == '0) ? TW'(TRfc - 1) :
                      r_trfc != '0 ? r_trfc - TW'(1) : r_trfc;
            if (w_en && w_cmd == C_MRS && w_mrs_ok) r_cl <= i_addr[6:4];
            for (int b = 0; b < 4; b++) begin
                if (w_act && i_ba == 2'(b)) begin
                    r_active[b] <= 1'b1;
                    r_row[b]    <= i_addr[RowStoreBits-1:0];
                    r_trcd[b]   <= TW'(TRcd - 1);
                end else if (r_trcd[b] != '0) r_trcd[b] <= r_trcd[b] - TW'(1);
                if ((w_pre && (i_addr[10] || i_ba == 2'(b))) || (w_acc && i_addr[10] && i_ba == 2'(b))) begin
                    r_active[b] <= 1'b0;
                    r_trp[b]    <= TW'(TRp - 1);
                end else if (r_trp[b] != '0) r_trp[b] <= r_trp[b] - TW'(1);
            end
            // Each read carries its own latency so a later MRS cannot retime it
            r_s1_v   <= w_acc && w_cmd == C_RD;
            r_s1_cl3 <= r_cl == 3'd3;
            r_s1_oe  <= {~i_udqm, ~i_ldqm};
            r_s1_dq  <= r_mem[w_idx];
            r_s2_v   <= r_s1_v && r_s1_cl3;
            r_s2_oe  <= r_s1_oe;
            r_s2_dq  <= r_s1_dq;
            o_dq_oe  <= (r_s1_v && !r_s1_cl3) ? r_s1_oe : r_s2_v ? r_s2_oe : 2'b00;
            o_dq     <= (r_s1_v && !r_s1_cl3) ? r_s1_dq : r_s2_v ? r_s2_dq : '0;
            if (!o_err && w_code != 3'd0) begin
                o_err      <= 1'b1;
                o_err_code <= w_code;
            end
        end
    end
endmodule

// File: tb/tb_sdram_device_responder.sv
// tb_sdram_device_responder: directed checks of init, read/write latency, masks, pipelining and error codes.
module tb_sdram_device_responder;
    localparam logic [3:0] NOP = 4'b0111, RD = 4'b0101, WR = 4'b0100, ACT = 4'b0011,
                           PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  ba = '0;
    logic [12:0] addr = '0;
    logic        ldqm = 1'b0, udqm = 1'b0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic [1:0]  dq_oe;
    logic        init_done, err;
    logic [2:0]  err_code;
    int          n_chk = 0;
    int          n_fail = 0;

    sdram_device_responder dut (
        .i_dram_clk (clk),
        .i_rst      (rst),
        .i_cs_n     (cs_n),
        .i_ras_n    (ras_n),
        .i_cas_n    (cas_n),
        .i_we_n     (we_n),
        .i_ba       (ba),
        .i_addr     (addr),
        .i_ldqm     (ldqm),
        .i_udqm     (udqm),
        .i_dq       (dq_in),
        .o_dq       (dq_out),
        .o_dq_oe    (dq_oe),
        .o_init_done(init_done),
        .o_err      (err),
        .o_err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] m);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = b;
        addr = a;
        dq_in = d;
        {udqm, ldqm} = m;
        @(posedge clk);
        #1;
        {cs_n, ras_n, cas_n, we_n} = NOP;
        {udqm, ldqm} = 2'b00;
    endtask

    task automatic nop(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        nop(2);
        rst = 1'b0;
    endtask

    task automatic do_init;
        issue(PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        issue(REF, 2'd0, 13'h000, 16'h0, 2'b00);
        nop(8);
        issue(REF, 2'd0, 13'h000, 16'h0, 2'b00);
        nop(8);
        issue(MRS, 2'd0, 13'h030, 16'h0, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset;
        chk("rst_init_done", 16'(init_done), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_err_code", 16'(err_code), 16'h0);
        chk("rst_oe", 16'(dq_oe), 16'h0);

        issue(PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        issue(REF, 2'd0, 13'h000, 16'h0, 2'b00);
        nop(8);
        issue(REF, 2'd0, 13'h000, 16'h0, 2'b00);
        nop(8);
        chk("init_pre_mrs", 16'(init_done), 16'h0);
        issue(MRS, 2'd0, 13'h030, 16'h0, 2'b00);
        chk("init_done", 16'(init_done), 16'h1);
        chk("init_err", 16'(err), 16'h0);

        // CL=3 write/read, WR exactly at tRCD
        issue(ACT, 2'd1, 13'h005, 16'h0, 2'b00);
        nop(2);
        issue(WR, 2'd1, 13'h003, 16'hBEEF, 2'b00);
        issue(RD, 2'd1, 13'h003, 16'h0, 2'b00);
        chk("cl3_k0_oe", 16'(dq_oe), 16'h0);
        nop(1);
        chk("cl3_k1_oe", 16'(dq_oe), 16'h0);
        nop(1);
        chk("cl3_k2_oe", 16'(dq_oe), 16'h3);
        chk("cl3_k2_dq", dq_out, 16'hBEEF);
        nop(1);
        chk("cl3_k3_oe", 16'(dq_oe), 16'h0);

        // CL=2
        issue(MRS, 2'd0, 13'h020, 16'h0, 2'b00);
        issue(RD, 2'd1, 13'h003, 16'h0, 2'b00);
        chk("cl2_k0_oe", 16'(dq_oe), 16'h0);
        nop(1);
        chk("cl2_k1_oe", 16'(dq_oe), 16'h3);
        chk("cl2_k1_dq", dq_out, 16'hBEEF);
        nop(1);
        chk("cl2_k2_oe", 16'(dq_oe), 16'h0);

        // byte masks
        issue(WR, 2'd1, 13'h003, 16'h1234, 2'b10);
        issue(RD, 2'd1, 13'h003, 16'h0, 2'b00);
        nop(1);
        chk("mask_wr_dq", dq_out, 16'hBE34);
        chk("mask_wr_oe", 16'(dq_oe), 16'h3);
        issue(RD, 2'd1, 13'h003, 16'h0, 2'b01);
        nop(1);
        chk("mask_rd_oe", 16'(dq_oe), 16'h2);

        // pipelined reads
        issue(WR, 2'd1, 13'h000, 16'h00A0, 2'b00);
        issue(WR, 2'd1, 13'h001, 16'h00A1, 2'b00);
        issue(WR, 2'd1, 13'h002, 16'h00A2, 2'b00);
        issue(RD, 2'd1, 13'h000, 16'h0, 2'b00);
        chk("pipe_pre_oe", 16'(dq_oe), 16'h0);
        issue(RD, 2'd1, 13'h001, 16'h0, 2'b00);
        chk("pipe_0", dq_out, 16'h00A0);
        chk("pipe_0_oe", 16'(dq_oe), 16'h3);
        issue(RD, 2'd1, 13'h002, 16'h0, 2'b00);
        chk("pipe_1", dq_out, 16'h00A1);
        nop(1);
        chk("pipe_2", dq_out, 16'h00A2);
        nop(1);
        chk("pipe_post_oe", 16'(dq_oe), 16'h0);

        // write after read and latency change do not disturb reads in flight
        issue(RD, 2'd1, 13'h000, 16'h0, 2'b00);
        issue(WR, 2'd1, 13'h000, 16'h5555, 2'b00);
        chk("wr_after_rd", dq_out, 16'h00A0);
        issue(RD, 2'd1, 13'h001, 16'h0, 2'b00);
        issue(MRS, 2'd0, 13'h030, 16'h0, 2'b00);
        chk("cl_change_old_rd", dq_out, 16'h00A1);
        issue(RD, 2'd1, 13'h000, 16'h0, 2'b00);
        nop(1);
        chk("cl_change_new_k1", 16'(dq_oe), 16'h0);
        nop(1);
        chk("cl_change_new_k2", dq_out, 16'h5555);
        chk("no_err_yet", 16'(err), 16'h0);

        // auto-precharge, then reset during an active read output
        issue(RD, 2'd1, 13'h403, 16'h0, 2'b00);
        issue(RD, 2'd1, 13'h003, 16'h0, 2'b00);
        chk("ap_err", 16'(err), 16'h1);
        chk("ap_code", 16'(err_code), 16'h2);
        nop(1);
        chk("ap_rd_oe", 16'(dq_oe), 16'h3);
        chk("ap_rd_dq", dq_out, 16'hBE34);
        rst = 1'b1;
        #1;
        chk("async_rst_oe", 16'(dq_oe), 16'h0);
        chk("async_rst_init", 16'(init_done), 16'h0);
        chk("async_rst_err", 16'(err), 16'h0);
        chk("async_rst_code", 16'(err_code), 16'h0);

        // RD to idle bank; later errors leave first code
        do_reset;
        do_init;
        issue(RD, 2'd0, 13'h000, 16'h0, 2'b00);
        chk("idle_rd_code", 16'(err_code), 16'h2);
        issue(ACT, 2'd2, 13'h000, 16'h0, 2'b00);
        issue(ACT, 2'd2, 13'h000, 16'h0, 2'b00);
        chk("sticky_err", 16'(err), 16'h1);
        chk("sticky_code", 16'(err_code), 16'h2);

        do_reset;
        do_init;
        issue(ACT, 2'd0, 13'h000, 16'h0, 2'b00);
        issue(RD, 2'd0, 13'h000, 16'h0, 2'b00);
        chk("trcd_code", 16'(err_code), 16'h4);

        do_reset;
        do_init;
        issue(ACT, 2'd0, 13'h000, 16'h0, 2'b00);
        chk("act_once_err", 16'(err), 16'h0);
        issue(ACT, 2'd0, 13'h000, 16'h0, 2'b00);
        chk("act_twice_code", 16'(err_code), 16'h3);

        do_reset;
        do_init;
        issue(MRS, 2'd0, 13'h031, 16'h0, 2'b00);
        chk("mrs_bad_err", 16'(err), 16'h1);
        chk("mrs_bad_code", 16'(err_code), 16'h6);

        do_reset;
        do_init;
        issue(ACT, 2'd0, 13'h000, 16'h0, 2'b00);
        nop(2);
        issue(PRE, 2'd0, 13'h000, 16'h0, 2'b00);
        issue(ACT, 2'd0, 13'h000, 16'h0, 2'b00);
        chk("trp_code", 16'(err_code), 16'h5);

        do_reset;
        do_init;
        issue(ACT, 2'd3, 13'h000, 16'h0, 2'b00);
        issue(REF, 2'd0, 13'h000, 16'h0, 2'b00);
        chk("ref_active_code", 16'(err_code), 16'h7);

        do_reset;
        issue(WR, 2'd0, 13'h000, 16'h1111, 2'b00);
        chk("wr_pre_init_err", 16'(err), 16'h1);
        chk("wr_pre_init_code", 16'(err_code), 16'h1);

        // command one cycle inside the refresh lockout
        do_reset;
        issue(PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        issue(REF, 2'd0, 13'h000, 16'h0, 2'b00);
        nop(7);
        issue(REF, 2'd0, 13'h000, 16'h0, 2'b00);
        chk("trfc_code", 16'(err_code), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_device_responder.md
Name: sdram_device_responder

Overview:
- Synthesizable SDRAM device-side responder: the chip end of the SDR SDRAM command interface that the controller drives.
- Decodes {CS,RAS,CAS,WE} commands and tracks the power-up sequence, per-bank open rows and tRCD/tRP timing.
- Stores write data in a reduced-depth array and returns read data after the programmed CAS latency.
- Used as the controller's bench/loopback target and protocol checker; bidirectional DQ split into in/out/enable.

Parameters:
AddrWidth, 13, row/column address bus width
DataWidth, 16, DQ width (two byte lanes)
RowStoreBits, 2, low row bits kept per bank (upper row bits ignored for storage)
ColStoreBits, 4, low column bits kept
TRcd, 3, min cycles ACT->RD/WR same bank
TRp, 3, min cycles PRE->ACT same bank
TRfc, 9, min cycles REF->any non-NOP command

Ports:
i_dram_clk  in  1  device clock, rising-edge sampled
i_rst  in  1  asynchronous active-high reset
i_cs_n  in  1  chip select
i_ras_n  in  1  row strobe
i_cas_n  in  1  column strobe
i_we_n  in  1  write enable
i_ba  in  2  bank address
i_addr  in  AddrWidth  row/column/mode address; bit10 = all-banks / auto-precharge
i_ldqm  in  1  low byte mask
i_udqm  in  1  high byte mask
i_dq  in  DataWidth  write data from controller
o_dq  out  DataWidth  read data
o_dq_oe  out  2  per-byte read drive enable {upper,lower}
o_init_done  out  1  power-up sequence complete
o_err  out  1  sticky protocol error
o_err_code  out  3  code of first error

Behaviour:
- Reset (async): all outputs 0; banks idle; timers 0; CL=3; init FSM = INIT_PALL; storage contents undefined.
- Command decode {cs,ras,cas,we}: CS=1 or 0111 = NOP; 0101 RD; 0100 WR; 0011 ACT; 0010 PRE (addr[10]=1 -> PALL); 0001 REF; 0000 MRS; 0110 (burst stop) -> treated as NOP.
- Init FSM: INIT_PALL --PALL--> INIT_REF1 --REF--> INIT_REF2 --REF--> INIT_MRS --MRS--> READY (o_init_done=1 next cycle). Non-NOP commands other than the expected one during init -> err 1, no state change. Any command within TRfc cycles after a REF -> err 1.
- MRS: CL=addr[6:4]; burst length addr[2:0] must be 000 and CL must be 2 or 3, else err 6 (CL keeps old value).
- ACT: bank idle and tRP elapsed -> bank active, row latched, tRCD timer loaded. Bank already active -> err 3; tRP not elapsed -> err 5. State is still updated in both cases.
- RD/WR: bank idle -> err 2, ignored. tRCD not elapsed -> err 4, access still performed.
  - Storage index = {ba, row[RowStoreBits-1:0], col[ColStoreBits-1:0]}.
  - addr[10]=1 -> auto-precharge: bank idle after the access, tRP timer loaded.
- WR: i_dq written on the command edge; a lane is written only when its dqm=0.
- RD: data and masks captured on command edge k. o_dq/o_dq_oe valid in the cycle after edge k+CL-1, so the controller samples them at edge k+CL; held exactly 1 cycle, then o_dq_oe=0. Lane oe = ~dqm sampled with RD.
  - Back-to-back RDs pipeline, one word per cycle.
  - A WR to the same location issued after a RD does not alter that in-flight read data.
  - A CL change via MRS does not affect reads already issued.
- PRE: addressed bank (or all, for PALL) -> idle, tRP timer loaded. PRE to an idle bank is legal (timer reloaded).
- REF in READY: any bank active -> err 7, otherwise TRfc lockout as in init.
- Errors: o_err set on the first error and held until reset; o_err_code holds the first code only; later errors are ignored.
- Timers saturate at 0. The command on edge k counts as cycle 0, so an ACT at edge k satisfies TRcd for a RD at edge k+TRcd.

Test Plan:
- Init: reset, PALL, REF, wait 9, REF, wait 9, MRS addr=0x030 -> o_init_done=1, o_err=0, CL=3.
- Write/read: ACT ba=1 row=0x005; after 3 cycles WR col=0x003 data 0xBEEF; RD col=0x003 at edge k -> o_dq=0xBEEF, o_dq_oe=2'b11 sampled at edge k+3 only. Repeat with MRS CL=2 -> valid at k+2.
- Masks: WR 0x1234 over 0xBEEF with udqm=1 -> readback 0xBE34. RD with ldqm=1 -> o_dq_oe=2'b10.
- Pipelined reads: RD col 0,1,2 on consecutive edges after writing 0xA0,0xA1,0xA2 -> three consecutive output cycles 0xA0,0xA1,0xA2, oe low before and after.
- Violations (fresh reset each): RD to idle bank -> err 2; ACT then RD after 1 cycle -> err 4; ACT twice -> err 3; MRS addr=0x031 -> err 6; WR before init done -> err 1.
- Auto-precharge/reset: RD with addr[10]=1, then RD same bank -> err 2; assert i_rst while a read is in flight -> o_dq_oe=0 immediately, o_init_done=0, o_err=0.
